// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU command driver and its golden model.
//   - alu_op_e    : op select {s1,s0} encodings
//   - drv_state_e : command driver FSM state encoding
//   - RES_W       : width of the ALU Out / result bus
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int RES_W = 5;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_CMP = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_RESP  = 2'b10
  } drv_state_e;

endpackage

// File: rtl/alu_golden_model.sv
// -----------------------------------------------------------------------------
// alu_golden_model
// Combinational reference for the 4-bit ALU; unsigned operands.
// Ports:
//   a, b      in  4  operands
//   op        in  2  {s1,s0}: 00 add, 01 sub, 10 compare, 11 AND
//   expected  out 5  reference value of the ALU Out bus
// -----------------------------------------------------------------------------
module alu_golden_model
  import alu_pkg::*;
(
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic [1:0]       op,
  output logic [RES_W-1:0] expected
);

  always_comb begin
    expected = '0;
    case (alu_op_e'(op))
      OP_ADD:  expected = {1'b0, a} + {1'b0, b};
      // Bit 4 is the borrow: set when the unsigned difference goes negative.
      OP_SUB:  expected = {(a < b), 4'(a - b)};
      OP_CMP:  expected = {2'b00, (a < b), (a == b), (a > b)};
      OP_AND:  expected = {1'b0, a & b};
      default: expected = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// alu_cmd_driver
// Sequential initiator for the 4-bit ALU. Accepts a command over valid/ready,
// drives the ALU inputs, waits SETTLE_CYCLES (legal 1..15), samples the ALU
// Out, compares it with the golden model and returns the outcome over a
// valid/ready response channel. Saturating pass/fail counters track accepted
// responses.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_a, cmd_b, cmd_op            operands and op select {s1,s0}
//   alu_a, alu_b, alu_s0, alu_s1    registered drive to the ALU
//   alu_out                         ALU Out bus
//   rsp_valid/rsp_ready             response handshake
//   rsp_result, rsp_expected        captured Out and golden value
//   rsp_mismatch                    rsp_result != rsp_expected
//   clear_stats                     synchronous clear of both counters
//   pass_count, fail_count          saturating statistics
// -----------------------------------------------------------------------------
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_s0,
  output logic             alu_s1,
  input  logic [RES_W-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_result,
  output logic [RES_W-1:0] rsp_expected,
  output logic             rsp_mismatch,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  drv_state_e       state;
  logic [3:0]       settle_cnt;
  logic [RES_W-1:0] golden;
  logic [RES_W-1:0] exp_hold;
  logic             rsp_accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Golden value is formed from the command as it is latched, so it is ready
  // long before the ALU output is sampled.
  alu_golden_model u_golden (
    .a        (cmd_a),
    .b        (cmd_b),
    .op       (cmd_op),
    .expected (golden)
  );

  assign rsp_accept = (state == ST_RESP) && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_s0       <= 1'b0;
      alu_s1       <= 1'b0;
      rsp_result   <= '0;
      rsp_expected <= '0;
      rsp_mismatch <= 1'b0;
      settle_cnt   <= '0;
      exp_hold     <= '0;
      pass_count   <= '0;
      fail_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_s1     <= cmd_op[1];
            alu_s0     <= cmd_op[0];
            exp_hold   <= golden;
            settle_cnt <= SETTLE_LD;
            cmd_ready  <= 1'b0;
            state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          settle_cnt <= settle_cnt - 4'd1;
          // Counter reaching zero on this edge marks the end of settling.
          if (settle_cnt == 4'd1) begin
            rsp_result   <= alu_out;
            rsp_expected <= exp_hold;
            rsp_mismatch <= (alu_out != exp_hold);
            rsp_valid    <= 1'b1;
            state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase

      // Clear takes priority over an increment on the same edge.
      if (clear_stats) begin
        pass_count <= '0;
        fail_count <= '0;
      end else if (rsp_accept) begin
        if (rsp_mismatch) fail_count <= sat_inc(fail_count);
        else              pass_count <= sat_inc(pass_count);
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

  typedef struct packed {
    logic [4:0] res;
    logic [4:0] exp;
    logic       mm;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: SETTLE_CYCLES=1, CNT_W=8
  logic       a_cmd_valid, a_cmd_ready;
  logic [3:0] a_cmd_a, a_cmd_b;
  logic [1:0] a_cmd_op;
  logic [3:0] a_alu_a, a_alu_b;
  logic       a_alu_s0, a_alu_s1;
  logic [4:0] a_alu_out;
  logic       a_rsp_valid, a_rsp_ready;
  logic [4:0] a_rsp_result, a_rsp_expected;
  logic       a_rsp_mismatch;
  logic       a_clear;
  logic [7:0] a_pass, a_fail;
  logic       a_fault;

  // Instance B: SETTLE_CYCLES=3, CNT_W=2
  logic       b_cmd_valid, b_cmd_ready;
  logic [3:0] b_cmd_a, b_cmd_b;
  logic [1:0] b_cmd_op;
  logic [3:0] b_alu_a, b_alu_b;
  logic       b_alu_s0, b_alu_s1;
  logic [4:0] b_alu_out;
  logic       b_rsp_valid, b_rsp_ready;
  logic [4:0] b_rsp_result, b_rsp_expected;
  logic       b_rsp_mismatch;
  logic       b_clear;
  logic [1:0] b_pass, b_fail;

  int checks = 0;
  int errors = 0;
  rsp_t q_a[$];
  rsp_t q_b[$];

  // Behavioural ALU standing in for the real one.
  function automatic logic [4:0] tb_alu(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0:    r = ia + ib;
      2'd1:    r = ((ia - ib) & 15) + ((ia < ib) ? 16 : 0);
      2'd2:    r = ((ia < ib) ? 4 : 0) + ((ia == ib) ? 2 : 0) + ((ia > ib) ? 1 : 0);
      default: r = ia & ib;
    endcase
    return r[4:0];
  endfunction

  assign a_alu_out = tb_alu(a_alu_a, a_alu_b, {a_alu_s1, a_alu_s0}) | {4'b0000, a_fault};
  assign b_alu_out = tb_alu(b_alu_a, b_alu_b, {b_alu_s1, b_alu_s0});

  alu_cmd_driver #(.SETTLE_CYCLES(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_a(a_cmd_a), .cmd_b(a_cmd_b), .cmd_op(a_cmd_op),
    .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_s0(a_alu_s0), .alu_s1(a_alu_s1),
    .alu_out(a_alu_out),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_result(a_rsp_result), .rsp_expected(a_rsp_expected),
    .rsp_mismatch(a_rsp_mismatch),
    .clear_stats(a_clear), .pass_count(a_pass), .fail_count(a_fail)
  );

  alu_cmd_driver #(.SETTLE_CYCLES(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_a(b_cmd_a), .cmd_b(b_cmd_b), .cmd_op(b_cmd_op),
    .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_s0(b_alu_s0), .alu_s1(b_alu_s1),
    .alu_out(b_alu_out),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_result(b_rsp_result), .rsp_expected(b_rsp_expected),
    .rsp_mismatch(b_rsp_mismatch),
    .clear_stats(b_clear), .pass_count(b_pass), .fail_count(b_fail)
  );

  // Issue one command to instance A; return latency (edges from acceptance to
  // rsp_valid) and the response fields seen when rsp_valid first rises.
  task automatic drive_a(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         output int lat, output rsp_t got, output bit to);
    int w;
    to = 1'b0; lat = 0; got = '0; w = 0;
    @(negedge clk);
    while (!a_cmd_ready && w < 50) begin @(negedge clk); w++; end
    if (!a_cmd_ready) begin to = 1'b1; return; end
    a_cmd_valid = 1'b1; a_cmd_a = a; a_cmd_b = b; a_cmd_op = op;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    while (!a_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!a_rsp_valid) to = 1'b1;
    got = {a_rsp_result, a_rsp_expected, a_rsp_mismatch};
  endtask

  task automatic drive_b(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         output int lat, output rsp_t got, output bit to);
    int w;
    to = 1'b0; lat = 0; got = '0; w = 0;
    @(negedge clk);
    while (!b_cmd_ready && w < 50) begin @(negedge clk); w++; end
    if (!b_cmd_ready) begin to = 1'b1; return; end
    b_cmd_valid = 1'b1; b_cmd_a = a; b_cmd_b = b; b_cmd_op = op;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    while (!b_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!b_rsp_valid) to = 1'b1;
    got = {b_rsp_result, b_rsp_expected, b_rsp_mismatch};
  endtask

  task automatic test_reset;
    checks++;
    if (a_cmd_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_a_hs got ready=%b valid=%b need 1 0", a_cmd_ready, a_rsp_valid);
    end
    checks++;
    if ({a_alu_a, a_alu_b, a_alu_s1, a_alu_s0, a_rsp_result, a_rsp_expected, a_rsp_mismatch} !== 21'd0) begin
      errors++; $display("FAIL reset_a_data got alu=%h/%h s=%b%b rsp=%h/%h/%b need all 0",
                         a_alu_a, a_alu_b, a_alu_s1, a_alu_s0, a_rsp_result, a_rsp_expected, a_rsp_mismatch);
    end
    checks++;
    if (a_pass !== 8'd0 || a_fail !== 8'd0 || b_pass !== 2'd0 || b_fail !== 2'd0) begin
      errors++; $display("FAIL reset_counts got a=%0d/%0d b=%0d/%0d need 0", a_pass, a_fail, b_pass, b_fail);
    end
    checks++;
    if (b_cmd_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_b_hs got ready=%b valid=%b need 1 0", b_cmd_ready, b_rsp_valid);
    end
  endtask

  task automatic test_add;
    logic [3:0] va [3] = '{4'd2, 4'd10, 4'd2};
    logic [3:0] vb [3] = '{4'd3, 4'd3,  4'd15};
    logic [4:0] vr [3] = '{5'b00101, 5'b01101, 5'b10001};
    rsp_t got, need;
    int lat;
    bit to;
    for (int i = 0; i < 3; i++) begin
      q_a.push_back({vr[i], vr[i], 1'b0});
      drive_a(va[i], vb[i], 2'b00, lat, got, to);
      need = q_a.pop_front();
      checks++;
      if (to || got !== need) begin
        errors++; $display("FAIL add[%0d] got res/exp/mm=%h need %h (timeout=%0b)", i, got, need, to);
      end
      checks++;
      if (lat != 1) begin
        errors++; $display("FAIL add_latency[%0d] got %0d need 1", i, lat);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (a_pass !== 8'd3 || a_fail !== 8'd0) begin
      errors++; $display("FAIL add_pass_count got %0d/%0d need 3/0", a_pass, a_fail);
    end
  endtask

  task automatic test_sub_cmp;
    logic [3:0] va [6] = '{4'd10, 4'd3, 4'd4, 4'd4, 4'd3, 4'b1100};
    logic [3:0] vb [6] = '{4'd3, 4'd10, 4'd3, 4'd4, 4'd4, 4'b1010};
    logic [1:0] vo [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [4:0] vr [6] = '{5'b00111, 5'b11001, 5'b00001, 5'b00010, 5'b00100, 5'b01000};
    rsp_t got, need;
    int lat;
    bit to;
    for (int i = 0; i < 6; i++) begin
      q_a.push_back({vr[i], vr[i], 1'b0});
      drive_a(va[i], vb[i], vo[i], lat, got, to);
      need = q_a.pop_front();
      checks++;
      if (to || got !== need) begin
        errors++; $display("FAIL subcmp[%0d] got res/exp/mm=%h need %h (timeout=%0b)", i, got, need, to);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (a_pass !== 8'd9) begin
      errors++; $display("FAIL subcmp_pass_count got %0d need 9", a_pass);
    end
  endtask

  task automatic test_fault;
    rsp_t got, need;
    int lat;
    bit to;
    a_fault = 1'b1;
    q_a.push_back({5'b01001, 5'b01000, 1'b1});
    drive_a(4'b1000, 4'b1010, 2'b11, lat, got, to);
    need = q_a.pop_front();
    checks++;
    if (to || got !== need) begin
      errors++; $display("FAIL fault_rsp got res/exp/mm=%h need %h (timeout=%0b)", got, need, to);
    end
    @(posedge clk); #1;
    a_fault = 1'b0;
    checks++;
    if (a_fail !== 8'd1 || a_pass !== 8'd9) begin
      errors++; $display("FAIL fault_counts got pass=%0d fail=%0d need 9 1", a_pass, a_fail);
    end
  endtask

  task automatic test_backpressure;
    rsp_t got, need;
    int lat;
    bit to;
    b_rsp_ready = 1'b0;
    q_b.push_back({5'b01011, 5'b01011, 1'b0});
    drive_b(4'd5, 4'd6, 2'b00, lat, got, to);
    need = q_b.pop_front();
    checks++;
    if (to || got !== need) begin
      errors++; $display("FAIL bp_rsp got res/exp/mm=%h need %h (timeout=%0b)", got, need, to);
    end
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL bp_latency got %0d need 3", lat);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b_cmd_valid = 1'b1; b_cmd_a = 4'(k); b_cmd_b = 4'd1; b_cmd_op = 2'b11;
      @(posedge clk); #1;
      checks++;
      if (b_rsp_valid !== 1'b1 || {b_rsp_result, b_rsp_expected, b_rsp_mismatch} !== need
          || b_cmd_ready !== 1'b0 || b_alu_a !== 4'd5 || b_pass !== 2'd0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b rsp=%h rdy=%b alu_a=%0d pass=%0d need 1 %h 0 5 0",
                           k, b_rsp_valid, {b_rsp_result, b_rsp_expected, b_rsp_mismatch},
                           b_cmd_ready, b_alu_a, b_pass, need);
      end
    end
    @(negedge clk);
    b_cmd_valid = 1'b0;
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b_rsp_valid !== 1'b0 || b_pass !== 2'd1 || b_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept got v=%b pass=%0d rdy=%b need 0 1 1", b_rsp_valid, b_pass, b_cmd_ready);
    end
  endtask

  task automatic test_saturation;
    rsp_t got, need;
    int lat;
    bit to;
    logic [1:0] want;
    @(negedge clk); b_clear = 1'b1;
    @(posedge clk); #1; b_clear = 1'b0;
    checks++;
    if (b_pass !== 2'd0) begin
      errors++; $display("FAIL sat_clear_idle got %0d need 0", b_pass);
    end
    for (int i = 0; i < 5; i++) begin
      q_b.push_back({5'(i + 1), 5'(i + 1), 1'b0});
      drive_b(4'(i), 4'd1, 2'b00, lat, got, to);
      need = q_b.pop_front();
      @(posedge clk); #1;
      want = (i >= 2) ? 2'd3 : 2'(i + 1);
      checks++;
      if (to || got !== need || b_pass !== want) begin
        errors++; $display("FAIL sat[%0d] got rsp=%h pass=%0d need %h %0d", i, got, b_pass, need, want);
      end
    end
    q_b.push_back({5'b00011, 5'b00011, 1'b0});
    drive_b(4'b0111, 4'b0011, 2'b11, lat, got, to);
    need = q_b.pop_front();
    checks++;
    if (to || got !== need || b_pass !== 2'd3) begin
      errors++; $display("FAIL sat_6th got rsp=%h pass=%0d need %h 3", got, b_pass, need);
    end
    @(negedge clk); b_clear = 1'b1;
    @(posedge clk); #1; b_clear = 1'b0;
    checks++;
    if (b_pass !== 2'd0 || b_fail !== 2'd0 || b_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL sat_clear_wins got pass=%0d fail=%0d v=%b need 0 0 0", b_pass, b_fail, b_rsp_valid);
    end
  endtask

  task automatic test_reset_mid;
    int w;
    bit seen;
    w = 0; seen = 1'b0;
    @(negedge clk);
    while (!a_cmd_ready && w < 50) begin @(negedge clk); w++; end
    a_cmd_valid = 1'b1; a_cmd_a = 4'd7; a_cmd_b = 4'd8; a_cmd_op = 2'b00;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_rsp_valid !== 1'b0 || a_cmd_ready !== 1'b1 || a_alu_a !== 4'd0 || a_alu_b !== 4'd0) begin
      errors++; $display("FAIL rstmid_state got v=%b rdy=%b alu=%h/%h need 0 1 0/0",
                         a_rsp_valid, a_cmd_ready, a_alu_a, a_alu_b);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (a_rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen || a_pass !== 8'd0 || a_fail !== 8'd0 || a_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_after got rsp_seen=%b pass=%0d fail=%0d rdy=%b need 0 0 0 1",
                         seen, a_pass, a_fail, a_cmd_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_cmd_valid = 1'b0; a_cmd_a = '0; a_cmd_b = '0; a_cmd_op = '0;
    a_rsp_ready = 1'b1; a_clear = 1'b0; a_fault = 1'b0;
    b_cmd_valid = 1'b0; b_cmd_a = '0; b_cmd_b = '0; b_cmd_op = '0;
    b_rsp_ready = 1'b1; b_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    test_reset;
    test_add;
    test_sub_cmp;
    test_fault;
    test_backpressure;
    test_saturation;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Sequential initiator for the 4-bit ALU. Accepts operation commands over a valid/ready handshake and drives the ALU's A, B, s0 and s1 inputs.
- Waits a programmable settle time, then captures the ALU's 5-bit Out. Checks the captured value against an internal golden model and returns the result over a valid/ready response channel.
- Keeps pass and fail counters. Sits between a command source (CPU-side sequencer or bench) and the ALU instance; allows in-system self-test of the ALU.

Parameters:
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before Out is sampled; legal range 1..15.
- CNT_W, 8, width of the pass/fail statistics counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_a  in  4  operand A.
- cmd_b  in  4  operand B.
- cmd_op  in  2  op select: {s1,s0}. 00 add, 01 sub, 10 compare, 11 AND.
- alu_a  out  4  to ALU A.
- alu_b  out  4  to ALU B.
- alu_s0  out  1  to ALU s0.
- alu_s1  out  1  to ALU s1.
- alu_out  in  5  from ALU Out.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  5  captured alu_out.
- rsp_expected  out  5  golden-model value.
- rsp_mismatch  out  1  rsp_result != rsp_expected.
- clear_stats  in  1  synchronous clear of both counters.
- pass_count  out  CNT_W  responses accepted with rsp_mismatch=0; saturating.
- fail_count  out  CNT_W  responses accepted with rsp_mismatch=1; saturating.

Behaviour:
- Reset values:
  - State IDLE; cmd_ready=1; rsp_valid=0.
  - alu_a, alu_b, alu_s0, alu_s1, rsp_result, rsp_expected, rsp_mismatch all 0.
  - Counters 0; settle counter 0.
- FSM states: IDLE, DRIVE, RESP.
  - IDLE: cmd_ready=1. If cmd_valid=1 at edge T, register cmd_a, cmd_b and cmd_op onto alu_a, alu_b and {alu_s1,alu_s0}; load settle counter with SETTLE_CYCLES; go DRIVE. Golden value is computed from the latched operands in the same edge.
  - DRIVE: cmd_ready=0. Decrement the settle counter each cycle. At the edge where it reaches 0 (edge T+SETTLE_CYCLES), register alu_out into rsp_result, set rsp_mismatch, set rsp_valid=1 and go RESP.
  - RESP: rsp_valid=1 and rsp_* held stable until rsp_ready=1 at an edge. At that edge: rsp_valid=0, update one counter, go IDLE. cmd_ready returns to 1 in the following cycle; there is no same-cycle command/response overlap.
- Latency: command accepted at edge T; rsp_valid is high from edge T+SETTLE_CYCLES. Minimum command-to-command spacing is SETTLE_CYCLES+2 cycles with rsp_ready tied high.
- ALU inputs: alu_* keep the last command's values in RESP and IDLE until the next command is accepted.
- Golden model (5-bit, unsigned operands):
  - add: {carry, A+B[3:0]}.
  - sub: {A<B, (A-B) mod 16}.
  - compare: {2'b00, A<B, A==B, A>B}.
  - AND: {1'b0, A&B}.
- Counters:
  - Saturate at all-ones; no wrap.
  - clear_stats wins over a simultaneous increment.
  - clear_stats does not affect the FSM.
- Reset mid-operation (DRIVE or RESP): in-flight command discarded, no counter update, all outputs to reset values on the next edge.
- Signals ignored outside their states: cmd_valid while not in IDLE; rsp_ready while not in RESP.

Decomposition:
- Shared package alu_pkg holds:
  - op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_CMP=2'b10, OP_AND=2'b11.
  - the FSM state encoding.
  - the 5-bit result width constant.
- One sub-module, alu_golden_model: combinational, (a, b, op) -> expected[4:0]. It is reused by benches.

Test Plan:
- Add, SETTLE_CYCLES=1, rsp_ready high, correct ALU:
  - A=2, B=3 -> rsp_result=5'b00101.
  - A=10, B=3 -> 5'b01101.
  - A=2, B=15 -> 5'b10001.
  - Each has mismatch=0, and rsp_valid rises exactly 1 cycle after acceptance. pass_count=3.
- Sub and compare:
  - sub 10-3 -> 5'b00111; sub 3-10 -> 5'b11001.
  - cmp 4 vs 3 -> 5'b00001; 4 vs 4 -> 5'b00010; 3 vs 4 -> 5'b00100.
  - AND 1100&1010 -> 5'b01000.
  - All mismatch=0.
- Fault injection: bench ALU forces Out bit0 stuck-at-1; AND 1000&1010 -> rsp_result=5'b01001, rsp_expected=5'b01000, rsp_mismatch=1, fail_count increments by 1.
- Backpressure, SETTLE_CYCLES=3: rsp_ready low for 5 cycles. Required: rsp_valid and rsp_* stable throughout, cmd_ready=0, new cmd_valid ignored, counter updates only on the accepting edge.
- Reset mid-DRIVE: assert rst one cycle after acceptance. Required: no rsp_valid ever, counters unchanged at 0, cmd_ready=1 after reset.
- Saturation, CNT_W=2: 5 passing commands -> pass_count=3. Then clear_stats asserted on the same edge as a 6th accepted response -> pass_count=0.
